// File: rtl/dtube_scan_driver_pkg.sv
// Purpose: shared constants for the 6-digit tube scan driver (glyphs, digit/pair counts).
// Latency: n/a (constants only).
// Backpressure: n/a.
package dtube_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int NUM_PAIRS  = 3;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/dtube_scan_driver_if.sv
// Purpose: bundle between clock logic and the scan driver: digit word, pair enables,
//          and the multiplexed segment/select/frame outputs toward the board pins.
// Latency/backpressure: none; plain level signals, no flow control.
interface dtube_scan_driver_if;
    logic [2:0]  DTube_en;     // pair enables: [2]=digits 5:4, [1]=3:2, [0]=1:0
    logic [2:0]  Twinkle_en;   // pair blink enables, same mapping
    logic [23:0] number_BCD;   // digit i = number_BCD[4i+3:4i]
    logic [7:0]  seg;          // {dp,g,f,e,d,c,b,a}
    logic [5:0]  dig_sel;      // one-hot digit select
    logic        frame_start;  // pulse with slot-0 outputs

    modport master (
        output DTube_en, Twinkle_en, number_BCD,
        input  seg, dig_sel, frame_start
    );

    modport slave (
        input  DTube_en, Twinkle_en, number_BCD,
        output seg, dig_sel, frame_start
    );
endinterface

// File: rtl/dtube_seg_decode.sv
// Purpose: BCD nibble to active-high 7-segment glyph; A-F show a dash so a bad digit is visible.
// Latency: combinational.
// Backpressure: none. Ports: nib (4b in), glyph (7b out, {g,f,e,d,c,b,a}).
module dtube_seg_decode
    import dtube_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        case (nib)
            4'd0: glyph = SEG_0;
            4'd1: glyph = SEG_1;
            4'd2: glyph = SEG_2;
            4'd3: glyph = SEG_3;
            4'd4: glyph = SEG_4;
            4'd5: glyph = SEG_5;
            4'd6: glyph = SEG_6;
            4'd7: glyph = SEG_7;
            4'd8: glyph = SEG_8;
            4'd9: glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/dtube_scan_driver.sv
// Purpose: time-multiplexes a 6-digit BCD word onto one segment bus with one-hot digit select,
//          per-pair blanking and twinkle; optional 2 Hz colon dp when DTUBE_DP_EN is defined.
// Latency: outputs registered; inputs snapshotted at slot 0 and shown from that edge. No backpressure.
// Ports: clk, rst (sync active-high), bus (slave: DTube_en, Twinkle_en, number_BCD in;
//        seg, dig_sel, frame_start out).
module dtube_scan_driver
    import dtube_pkg::*;
#(
    parameter int SCAN_DIV       = 1,
    parameter int BLINK_HALF     = 250,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dtube_scan_driver_if.slave   bus
);

    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = $clog2(2 * BLINK_HALF);

    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic [23:0]        snap_bcd;
    logic [2:0]         snap_en;
    logic [2:0]         snap_tw;
    logic [7:0]         seg_q;
    logic [5:0]         sel_q;
    logic               fs_q;

    logic               advance;
    logic               enter0;
    logic [2:0]         next_idx;
    logic [23:0]        cur_bcd;
    logic [2:0]         cur_en;
    logic [2:0]         cur_tw;
    logic [1:0]         pair;
    logic               blink_on;
    logic               blank;
    logic               dp_on;
    logic [3:0]         nib;
    logic [6:0]         glyph;
    logic [7:0]         seg_int;
    logic [5:0]         sel_int;

    // A slot begins on every edge where div_cnt is 0; reset parks idx at 5 so the
    // first edge after release lands in slot 0.
    assign advance  = (div_cnt == '0);
    assign next_idx = advance ? ((idx == 3'd5) ? 3'd0 : 3'(idx + 3'd1)) : idx;
    assign enter0   = advance && (idx == 3'd5);

    // Slot 0 shows the live inputs on the capture edge; later slots use the snapshot.
    assign cur_bcd  = enter0 ? bus.number_BCD : snap_bcd;
    assign cur_en   = enter0 ? bus.DTube_en   : snap_en;
    assign cur_tw   = enter0 ? bus.Twinkle_en : snap_tw;

    assign pair     = next_idx[2:1];
    assign blink_on = (blink_cnt < BLINK_W'(BLINK_HALF));
    assign blank    = !cur_en[pair] || (cur_tw[pair] && !blink_on);

    always_comb begin
        nib = 4'd0;
        case (next_idx)
            3'd0:    nib = cur_bcd[3:0];
            3'd1:    nib = cur_bcd[7:4];
            3'd2:    nib = cur_bcd[11:8];
            3'd3:    nib = cur_bcd[15:12];
            3'd4:    nib = cur_bcd[19:16];
            default: nib = cur_bcd[23:20];
        endcase
    end

    dtube_seg_decode u_dec (
        .nib   (nib),
        .glyph (glyph)
    );

`ifdef DTUBE_DP_EN
    // Colon separators sit on digits 2 and 4 and flash with the twinkle phase.
    assign dp_on = !blank && blink_on && ((next_idx == 3'd2) || (next_idx == 3'd4));
`else
    assign dp_on = 1'b0;
`endif

    assign seg_int = blank ? {1'b0, SEG_BLANK} : {dp_on, glyph};
    assign sel_int = blank ? 6'd0 : (6'd1 << next_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            idx       <= 3'd5;
            blink_cnt <= '0;
            snap_bcd  <= '0;
            snap_en   <= '0;
            snap_tw   <= '0;
            seg_q     <= (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
            sel_q     <= (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
            fs_q      <= 1'b0;
        end else begin
            div_cnt   <= (div_cnt == DIV_W'(SCAN_DIV - 1)) ? '0 : DIV_W'(div_cnt + 1'b1);
            idx       <= next_idx;
            blink_cnt <= (blink_cnt == BLINK_W'(2 * BLINK_HALF - 1)) ? '0
                                                                      : BLINK_W'(blink_cnt + 1'b1);
            if (enter0) begin
                snap_bcd <= bus.number_BCD;
                snap_en  <= bus.DTube_en;
                snap_tw  <= bus.Twinkle_en;
            end
            seg_q     <= (SEG_ACTIVE_LOW != 0) ? ~seg_int : seg_int;
            sel_q     <= (SEL_ACTIVE_LOW != 0) ? ~sel_int : sel_int;
            fs_q      <= enter0;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dig_sel     = sel_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_dtube_scan_driver.sv
// Purpose: random + directed bench for dtube_scan_driver, two parameterisations driven in lockstep.
// Latency: expected values computed per edge from elapsed cycles since reset release.
// Backpressure: none.
module tb_dtube_scan_driver;

    logic        clk;
    logic        rst;
    logic [23:0] bcd;
    logic [2:0]  en;
    logic [2:0]  tw;

    dtube_scan_driver_if if_a ();
    dtube_scan_driver_if if_b ();

    assign if_a.number_BCD = bcd;
    assign if_a.DTube_en   = en;
    assign if_a.Twinkle_en = tw;
    assign if_b.number_BCD = bcd;
    assign if_b.DTube_en   = en;
    assign if_b.Twinkle_en = tw;

    dtube_scan_driver #(.SCAN_DIV(1), .BLINK_HALF(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    dtube_scan_driver #(.SCAN_DIV(3), .BLINK_HALF(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int          div_p [2] = '{1, 3};
    int          bh_p  [2] = '{4, 5};
    int          cyc   [2];
    logic [23:0] m_bcd [2];
    logic [2:0]  m_en  [2];
    logic [2:0]  m_tw  [2];
    logic [7:0]  exp_seg [2];
    logic [5:0]  exp_sel [2];
    logic        exp_fs  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Standard active-high 7-segment table {g..a}; A-F render as a dash.
    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (n > 4'd9) return 7'h40;
        return t[n];
    endfunction

    // Expected outputs after the coming edge, from elapsed cycles since release.
    task automatic predict();
        int slot, bc, p;
        logic lit, dp;
        logic [3:0] nib;
        logic [5:0] one;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                exp_seg[k] = 8'hFF;
                exp_sel[k] = 6'h3F;
                exp_fs[k]  = 1'b0;
                cyc[k]     = 0;
            end else begin
                slot = (cyc[k] / div_p[k]) % 6;
                if ((cyc[k] % (6 * div_p[k])) == 0) begin
                    m_bcd[k] = bcd;
                    m_en[k]  = en;
                    m_tw[k]  = tw;
                end
                bc  = cyc[k] % (2 * bh_p[k]);
                p   = slot / 2;
                lit = m_en[k][p] && !(m_tw[k][p] && (bc >= bh_p[k]));
                nib = 4'((m_bcd[k] >> (4 * slot)) & 24'hF);
                dp  = 1'b0;
`ifdef DTUBE_DP_EN
                dp  = ((slot == 2) || (slot == 4)) && (bc < bh_p[k]);
`endif
                if (lit) begin
                    one        = 6'd1 << slot;
                    exp_sel[k] = ~one;
                    exp_seg[k] = ~{dp, ref_glyph(nib)};
                end else begin
                    exp_sel[k] = 6'h3F;
                    exp_seg[k] = 8'hFF;
                end
                exp_fs[k] = ((cyc[k] % (6 * div_p[k])) == 0);
                cyc[k]++;
            end
        end
    endtask

    task automatic stimulus(input int n);
        rst = 1'b0;
        if (n < 3) begin
            rst = 1'b1; bcd = 24'h123456; en = 3'b111; tw = 3'b000;
        end else if (n < 40) begin
            bcd = 24'h123456; en = 3'b111; tw = 3'b000;
        end else if (n < 70) begin
            en = 3'b110;
        end else if (n < 110) begin
            en = 3'b111; tw = 3'b100;
        end else if (n < 130) begin
            bcd = 24'hFEDCBA; tw = 3'b000;
        end else if (n == 135) begin
            rst = 1'b1;
        end else if (n > 135) begin
            bcd = 24'($urandom);
            if ($urandom_range(0, 3) == 0) en = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) tw = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 49) == 0);
        end
    endtask

    initial begin
        stimulus(0);
        predict();
        for (int n = 1; n < 700; n++) begin
            @(negedge clk);
            check_eq("a.seg",     32'(if_a.seg),         32'(exp_seg[0]));
            check_eq("a.dig_sel", 32'(if_a.dig_sel),     32'(exp_sel[0]));
            check_eq("a.frame",   32'(if_a.frame_start), 32'(exp_fs[0]));
            check_eq("b.seg",     32'(if_b.seg),         32'(exp_seg[1]));
            check_eq("b.dig_sel", 32'(if_b.dig_sel),     32'(exp_sel[1]));
            check_eq("b.frame",   32'(if_b.frame_start), 32'(exp_fs[1]));
            stimulus(n);
            predict();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
